// File: rtl/program_loader_if.sv
// Byte-link and instruction-memory write bundle for program_loader.
// The host side uses the master modport, the loader uses the slave modport.
interface program_loader_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        imem_we;
  logic [15:0] imem_addr;
  logic [15:0] imem_wdata;
  logic        cpu_run;
  logic        busy;
  logic        err;
  logic [15:0] words_loaded;

  modport master (
    output rx_data, rx_valid,
    input  rx_ready, imem_we, imem_addr, imem_wdata, cpu_run, busy, err, words_loaded
  );

  modport slave (
    input  rx_data, rx_valid,
    output rx_ready, imem_we, imem_addr, imem_wdata, cpu_run, busy, err, words_loaded
  );
endinterface

// File: rtl/program_loader.sv
// Assembles a big-endian byte stream (count, then hi/lo word pairs) into 16-bit words,
// writes them to instruction memory and then releases the processor. Optional: CHECKSUM_EN.
module program_loader #(
  parameter logic [15:0] START_ADDR = 16'd10,
  parameter logic [15:0] ADDR_STEP  = 16'd2
) (
  input  logic            clk,
  input  logic            rst_n,
  program_loader_if.slave bus
);

`ifdef CHECKSUM_EN
  typedef enum logic [2:0] {
    S_IDLE, S_CNT_LO, S_DATA_HI, S_DATA_LO, S_CHECK, S_DONE, S_ERROR
  } state_t;
  localparam state_t S_TAIL = S_CHECK;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_CNT_LO, S_DATA_HI, S_DATA_LO, S_DONE
  } state_t;
  localparam state_t S_TAIL = S_DONE;
`endif

  state_t      state_q, state_d;
  logic [7:0]  hi_q, hi_d;
  logic [15:0] rem_q, rem_d;
  logic        rx_ready_q, rx_ready_d;
  logic        imem_we_q, imem_we_d;
  logic [15:0] imem_addr_q, imem_addr_d;
  logic [15:0] imem_wdata_q, imem_wdata_d;
  logic        cpu_run_q, cpu_run_d;
  logic        busy_q, busy_d;
  logic [15:0] words_q, words_d;
  logic        accept;
`ifdef CHECKSUM_EN
  logic [7:0]  xor_q, xor_d;
  logic        err_q, err_d;
`endif

  // Address arithmetic is deliberately modulo 2^16.
  function automatic logic [15:0] next_addr(input logic [15:0] a);
    return a + ADDR_STEP;
  endfunction

  function automatic logic takes_bytes(input state_t s);
    logic r;
    r = 1'b0;
    case (s)
      S_IDLE, S_CNT_LO, S_DATA_HI, S_DATA_LO: r = 1'b1;
`ifdef CHECKSUM_EN
      S_CHECK:                                r = 1'b1;
`endif
      default:                                r = 1'b0;
    endcase
    return r;
  endfunction

  assign accept = bus.rx_valid & rx_ready_q;

  always_comb begin
    state_d      = state_q;
    hi_d         = hi_q;
    rem_d        = rem_q;
    imem_we_d    = 1'b0;
    imem_wdata_d = imem_wdata_q;
    imem_addr_d  = imem_we_q ? next_addr(imem_addr_q) : imem_addr_q;
`ifdef CHECKSUM_EN
    xor_d        = xor_q;
`endif
    if (accept) begin
`ifdef CHECKSUM_EN
      if (state_q != S_CHECK) xor_d = xor_q ^ bus.rx_data;
`endif
      case (state_q)
        S_IDLE: begin
          hi_d    = bus.rx_data;
          state_d = S_CNT_LO;
        end
        S_CNT_LO: begin
          rem_d   = {hi_q, bus.rx_data};
          state_d = ({hi_q, bus.rx_data} == 16'd0) ? S_TAIL : S_DATA_HI;
        end
        S_DATA_HI: begin
          hi_d    = bus.rx_data;
          state_d = S_DATA_LO;
        end
        S_DATA_LO: begin
          imem_we_d    = 1'b1;
          imem_wdata_d = {hi_q, bus.rx_data};
          rem_d        = rem_q - 16'd1;
          state_d      = (rem_q == 16'd1) ? S_TAIL : S_DATA_HI;
        end
`ifdef CHECKSUM_EN
        S_CHECK: begin
          state_d = (bus.rx_data == xor_q) ? S_DONE : S_ERROR;
        end
`endif
        default: state_d = state_q;
      endcase
    end
    words_d    = words_q + {15'd0, imem_we_d};
    rx_ready_d = takes_bytes(state_d);
    busy_d     = takes_bytes(state_d) && (state_d != S_IDLE);
    // Release lags DONE by one cycle so it never coincides with the final strobe.
    cpu_run_d  = (state_q == S_DONE);
`ifdef CHECKSUM_EN
    err_d      = (state_d == S_ERROR);
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      hi_q         <= 8'd0;
      rem_q        <= 16'd0;
      rx_ready_q   <= 1'b0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= START_ADDR;
      imem_wdata_q <= 16'd0;
      cpu_run_q    <= 1'b0;
      busy_q       <= 1'b0;
      words_q      <= 16'd0;
`ifdef CHECKSUM_EN
      xor_q        <= 8'd0;
      err_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      hi_q         <= hi_d;
      rem_q        <= rem_d;
      rx_ready_q   <= rx_ready_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      cpu_run_q    <= cpu_run_d;
      busy_q       <= busy_d;
      words_q      <= words_d;
`ifdef CHECKSUM_EN
      xor_q        <= xor_d;
      err_q        <= err_d;
`endif
    end
  end

  assign bus.rx_ready     = rx_ready_q;
  assign bus.imem_we      = imem_we_q;
  assign bus.imem_addr    = imem_addr_q;
  assign bus.imem_wdata   = imem_wdata_q;
  assign bus.cpu_run      = cpu_run_q;
  assign bus.busy         = busy_q;
  assign bus.words_loaded = words_q;
`ifdef CHECKSUM_EN
  assign bus.err          = err_q;
`else
  assign bus.err          = 1'b0;
`endif

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader; a second instance starting at 16'hFFFC runs in
// lockstep on the same byte stream to exercise address wrap.
module tb_program_loader;
  logic clk;
  logic rst_n;
  int   checks;
  int   fails;

`ifdef CHECKSUM_EN
  localparam bit CK_EN = 1'b1;
`else
  localparam bit CK_EN = 1'b0;
`endif

  program_loader_if bus ();
  program_loader_if bus_w ();

  program_loader #(.START_ADDR(16'd10), .ADDR_STEP(16'd2)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  program_loader #(.START_ADDR(16'hFFFC), .ADDR_STEP(16'd2)) dut_w (
    .clk(clk), .rst_n(rst_n), .bus(bus_w)
  );

  assign bus_w.rx_data  = bus.rx_data;
  assign bus_w.rx_valid = bus.rx_valid;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]  stim[$];
  logic [15:0] log_a[$];
  logic [15:0] log_d[$];
  logic [15:0] wlog_a[$];
  int   cyc = 0;
  int   last_we = -1;
  int   run_rise = -1;
  int   overlap = 0;
  logic run_prev = 1'b0;

  // Observe the settled values of each cycle, just after the active edge.
  always @(posedge clk) begin
    #1;
    cyc = cyc + 1;
    if (bus.imem_we === 1'b1) begin
      log_a.push_back(bus.imem_addr);
      log_d.push_back(bus.imem_wdata);
      last_we = cyc;
    end
    if (bus.imem_we === 1'b1 && bus.cpu_run === 1'b1) overlap = overlap + 1;
    if (bus.cpu_run === 1'b1 && run_prev !== 1'b1) run_rise = cyc;
    run_prev = bus.cpu_run;
    if (bus_w.imem_we === 1'b1) wlog_a.push_back(bus_w.imem_addr);
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.rx_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    log_a.delete();
    log_d.delete();
    wlog_a.delete();
    last_we = -1;
    run_rise = -1;
  endtask

  task automatic send(input bit toggle, input bit add_ck);
    int i;
    int budget;
    bit gap;
    logic [7:0] ck;
    if (add_ck) begin
      ck = 8'h00;
      foreach (stim[j]) ck = ck ^ stim[j];
      stim.push_back(ck);
    end
    i = 0;
    budget = 0;
    gap = 1'b0;
    while (i < stim.size() && budget < 200) begin
      @(negedge clk);
      budget++;
      if (toggle && gap) begin
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'hFF;
        gap = 1'b0;
      end else begin
        bus.rx_valid = 1'b1;
        bus.rx_data  = stim[i];
        if (bus.rx_ready === 1'b1) begin
          i++;
          gap = 1'b1;
        end
      end
    end
    @(negedge clk);
    bus.rx_valid = 1'b0;
    checks++;
    if (i !== stim.size()) begin
      fails++;
      $display("FAIL send_stream: accepted %0d bytes, required %0d", i, stim.size());
    end
  endtask

  task automatic wait_run(input int max_cycles);
    int n;
    n = 0;
    while (bus.cpu_run !== 1'b1 && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'h5A;
    @(negedge clk);
    @(negedge clk);
    checks++; if (bus.rx_ready !== 1'b0) begin fails++; $display("FAIL reset_rx_ready: got %b expected 0", bus.rx_ready); end
    checks++; if (bus.imem_we !== 1'b0) begin fails++; $display("FAIL reset_imem_we: got %b expected 0", bus.imem_we); end
    checks++; if (bus.imem_addr !== 16'h000A) begin fails++; $display("FAIL reset_imem_addr: got %h expected 000a", bus.imem_addr); end
    checks++; if (bus.imem_wdata !== 16'h0000) begin fails++; $display("FAIL reset_imem_wdata: got %h expected 0000", bus.imem_wdata); end
    checks++; if (bus.cpu_run !== 1'b0) begin fails++; $display("FAIL reset_cpu_run: got %b expected 0", bus.cpu_run); end
    checks++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.err !== 1'b0) begin fails++; $display("FAIL reset_err: got %b expected 0", bus.err); end
    checks++; if (bus.words_loaded !== 16'd0) begin fails++; $display("FAIL reset_words: got %0d expected 0", bus.words_loaded); end
    bus.rx_valid = 1'b0;
  endtask

  task automatic test_basic();
    do_reset();
    stim = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
    send(1'b0, CK_EN);
    wait_run(20);
    checks++; if (log_a.size() !== 2) begin fails++; $display("FAIL basic_nwrites: got %0d expected 2", log_a.size()); end
    checks++; if (log_a[0] !== 16'h000A || log_d[0] !== 16'h1234) begin fails++; $display("FAIL basic_write0: got %h/%h expected 000a/1234", log_a[0], log_d[0]); end
    checks++; if (log_a[1] !== 16'h000C || log_d[1] !== 16'hABCD) begin fails++; $display("FAIL basic_write1: got %h/%h expected 000c/abcd", log_a[1], log_d[1]); end
    checks++; if (bus.words_loaded !== 16'd2) begin fails++; $display("FAIL basic_words: got %0d expected 2", bus.words_loaded); end
    checks++; if (bus.cpu_run !== 1'b1) begin fails++; $display("FAIL basic_cpu_run: got %b expected 1", bus.cpu_run); end
    checks++; if (bus.rx_ready !== 1'b0) begin fails++; $display("FAIL basic_rx_ready: got %b expected 0", bus.rx_ready); end
    checks++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL basic_busy: got %b expected 0", bus.busy); end
`ifdef CHECKSUM_EN
    checks++; if (run_rise <= last_we) begin fails++; $display("FAIL basic_run_timing: run at %0d, last strobe %0d", run_rise, last_we); end
`else
    checks++; if (run_rise !== last_we + 1) begin fails++; $display("FAIL basic_run_timing: run at %0d expected %0d", run_rise, last_we + 1); end
`endif
  endtask

  task automatic test_zero_count();
    do_reset();
    stim = '{8'h00, 8'h00};
    send(1'b0, CK_EN);
    wait_run(20);
    checks++; if (log_a.size() !== 0) begin fails++; $display("FAIL zero_nwrites: got %0d expected 0", log_a.size()); end
    checks++; if (bus.cpu_run !== 1'b1) begin fails++; $display("FAIL zero_cpu_run: got %b expected 1", bus.cpu_run); end
    checks++; if (bus.words_loaded !== 16'd0) begin fails++; $display("FAIL zero_words: got %0d expected 0", bus.words_loaded); end
  endtask

  task automatic test_toggle();
    do_reset();
    stim = '{8'h00, 8'h01, 8'hBE, 8'hEF};
    send(1'b1, CK_EN);
    wait_run(20);
    checks++; if (log_a.size() !== 1) begin fails++; $display("FAIL toggle_nwrites: got %0d expected 1", log_a.size()); end
    checks++; if (log_a[0] !== 16'h000A || log_d[0] !== 16'hBEEF) begin fails++; $display("FAIL toggle_write: got %h/%h expected 000a/beef", log_a[0], log_d[0]); end
    checks++; if (bus.words_loaded !== 16'd1) begin fails++; $display("FAIL toggle_words: got %0d expected 1", bus.words_loaded); end
    checks++; if (bus.cpu_run !== 1'b1) begin fails++; $display("FAIL toggle_cpu_run: got %b expected 1", bus.cpu_run); end
  endtask

  task automatic test_reset_mid_load();
    do_reset();
    stim = '{8'h00, 8'h03, 8'h11, 8'h22, 8'h33};
    send(1'b0, 1'b0);
    @(negedge clk);
    checks++; if (log_a.size() !== 1 || log_d[0] !== 16'h1122) begin fails++; $display("FAIL mid_partial: got %0d writes, first %h, expected 1 write 1122", log_a.size(), log_d[0]); end
    checks++; if (bus.busy !== 1'b1) begin fails++; $display("FAIL mid_busy: got %b expected 1", bus.busy); end
    checks++; if (bus.cpu_run !== 1'b0) begin fails++; $display("FAIL mid_cpu_run: got %b expected 0", bus.cpu_run); end
    do_reset();
    checks++; if (bus.words_loaded !== 16'd0 || bus.imem_addr !== 16'h000A) begin fails++; $display("FAIL mid_after_reset: got words %0d addr %h expected 0/000a", bus.words_loaded, bus.imem_addr); end
    checks++; if (bus.busy !== 1'b0 || bus.cpu_run !== 1'b0) begin fails++; $display("FAIL mid_after_reset_flags: got busy %b run %b expected 0/0", bus.busy, bus.cpu_run); end
    stim = '{8'h00, 8'h01, 8'h55, 8'h66};
    send(1'b0, CK_EN);
    wait_run(20);
    checks++; if (log_a.size() !== 1) begin fails++; $display("FAIL mid_reload_nwrites: got %0d expected 1", log_a.size()); end
    checks++; if (log_a[0] !== 16'h000A || log_d[0] !== 16'h5566) begin fails++; $display("FAIL mid_reload_write: got %h/%h expected 000a/5566", log_a[0], log_d[0]); end
    checks++; if (bus.cpu_run !== 1'b1) begin fails++; $display("FAIL mid_reload_run: got %b expected 1", bus.cpu_run); end
  endtask

  task automatic test_reset_collision();
    do_reset();
    stim = '{8'h00, 8'h01, 8'hAA};
    send(1'b0, 1'b0);
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'hBB;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    bus.rx_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (log_a.size() !== 0) begin fails++; $display("FAIL collide_nwrites: got %0d expected 0", log_a.size()); end
    checks++; if (bus.words_loaded !== 16'd0) begin fails++; $display("FAIL collide_words: got %0d expected 0", bus.words_loaded); end
    checks++; if (bus.busy !== 1'b0 || bus.rx_ready !== 1'b1) begin fails++; $display("FAIL collide_state: got busy %b ready %b expected 0/1", bus.busy, bus.rx_ready); end
  endtask

  task automatic test_addr_wrap();
    do_reset();
    stim = '{8'h00, 8'h03, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    send(1'b0, CK_EN);
    wait_run(20);
    checks++; if (wlog_a.size() !== 3) begin fails++; $display("FAIL wrap_nwrites: got %0d expected 3", wlog_a.size()); end
    checks++; if (wlog_a[0] !== 16'hFFFC || wlog_a[1] !== 16'hFFFE || wlog_a[2] !== 16'h0000) begin fails++; $display("FAIL wrap_addrs: got %h %h %h expected fffc fffe 0000", wlog_a[0], wlog_a[1], wlog_a[2]); end
    checks++; if (bus_w.words_loaded !== 16'd3 || bus_w.cpu_run !== 1'b1) begin fails++; $display("FAIL wrap_done: got words %0d run %b expected 3/1", bus_w.words_loaded, bus_w.cpu_run); end
  endtask

`ifdef CHECKSUM_EN
  task automatic test_checksum();
    do_reset();
    stim = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h27};
    send(1'b0, 1'b0);
    wait_run(20);
    checks++; if (bus.cpu_run !== 1'b1 || bus.err !== 1'b0) begin fails++; $display("FAIL ck_good: got run %b err %b expected 1/0", bus.cpu_run, bus.err); end
    checks++; if (log_d.size() !== 1 || log_d[0] !== 16'h1234) begin fails++; $display("FAIL ck_good_write: got %0d writes %h expected 1 write 1234", log_d.size(), log_d[0]); end
    do_reset();
    stim = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h00};
    send(1'b0, 1'b0);
    repeat (3) @(negedge clk);
    checks++; if (bus.err !== 1'b1) begin fails++; $display("FAIL ck_bad_err: got %b expected 1", bus.err); end
    checks++; if (bus.cpu_run !== 1'b0) begin fails++; $display("FAIL ck_bad_run: got %b expected 0", bus.cpu_run); end
    checks++; if (bus.rx_ready !== 1'b0) begin fails++; $display("FAIL ck_bad_ready: got %b expected 0", bus.rx_ready); end
  endtask
`endif

  initial begin
    checks = 0;
    fails  = 0;
    rst_n  = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    test_reset();
    test_basic();
    test_zero_count();
    test_toggle();
    test_reset_mid_load();
    test_reset_collision();
    test_addr_wrap();
`ifdef CHECKSUM_EN
    test_checksum();
`endif
    checks++;
    if (overlap !== 0) begin
      fails++;
      $display("FAIL run_with_strobe: got %0d overlapping cycles expected 0", overlap);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
